imm_extend_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 4/8/12-bit sign extender.
- Takes a raw immediate field of runtime-selectable width. Sign- or zero-extends it to OUT_W and applies an optional left shift for scaled branch/jump offsets.
- Sits between decode and execute. Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/imm_extend_pipe.sv | 175 +++++++++++++++++
 tb/tb_imm_extend_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//   Two-stage pipelined immediate extender. A raw immediate field of runtime
//   width (field_w) is sign- or zero-extended to OUT_W and then shifted left
//   by shamt. Valid/ready handshake on both sides, throughput 1 item/cycle.
//   An illegal field_w (0 or > IN_W) is handled as a full-width, zero-extended
//   field, and out_err is raised for that item.
//
// Optional build macro: IMM_OVF_DETECT_EN
//   Adds out_ovf, which flags that the shifted value does not fit in OUT_W.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    upstream handshake
//   in_imm [IN_W]          raw immediate, field in bits [field_w-1:0]
//   field_w [FW_W]         field width, legal range 1..IN_W
//   sign_en                1 = sign-extend, 0 = zero-extend
//   shamt [SH_W]           left shift applied after extension
//   out_valid / out_ready  downstream handshake
//   out_imm [OUT_W]        extended and shifted result
//   out_err                illegal field_w seen for this item
//   out_ovf                (IMM_OVF_DETECT_EN only) result not representable
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned FW_W  = $clog2(IN_W + 1),
  parameter int unsigned SH_W  = $clog2(OUT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [FW_W-1:0]  field_w,
  input  logic             sign_en,
  input  logic [SH_W-1:0]  shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_err
`ifdef IMM_OVF_DETECT_EN
  ,
  output logic             out_ovf
`endif
);

  // Handshake control
  logic w_in_fire;
  logic w_s1_adv;

  // Stage 1
  logic             r_s1_valid;
  logic [IN_W-1:0]  r_s1_field;
  logic             r_s1_ext;
  logic [SH_W-1:0]  r_s1_sh;
  logic             r_s1_err;

  logic             w_legal;
  logic             w_ext;
  logic [IN_W-1:0]  w_field;

  // Stage 2
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_imm;
  logic             r_out_err;

  logic [OUT_W-1:0] w_ext_val;
  logic [OUT_W-1:0] w_shifted;

  assign w_s1_adv  = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready  = ~r_s1_valid | w_s1_adv;
  assign w_in_fire = in_valid & in_ready;

  assign out_valid = r_out_valid;
  assign out_imm   = r_out_imm;
  assign out_err   = r_out_err;

  // The bits of the IN_W field above field_w are filled with the extension
  // bit here already, so stage 2 only has to replicate r_s1_ext above IN_W.
  always_comb begin
    w_legal = (field_w != '0) && (32'(field_w) <= IN_W);
    w_ext   = 1'b0;
    w_field = in_imm;
    if (w_legal) begin
      for (int unsigned i = 0; i < IN_W; i++) begin
        if (i + 1 == 32'(field_w)) w_ext = sign_en & in_imm[i];
      end
      for (int unsigned i = 0; i < IN_W; i++) begin
        if (i >= 32'(field_w)) w_field[i] = w_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_field <= '0;
      r_s1_ext   <= 1'b0;
      r_s1_sh    <= '0;
      r_s1_err   <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_field <= w_field;
        r_s1_ext   <= w_ext;
        r_s1_sh    <= shamt;
        r_s1_err   <= ~w_legal;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_ext_val = OUT_W'(r_s1_field);
    for (int unsigned i = IN_W; i < OUT_W; i++) begin
      w_ext_val[i] = r_s1_ext;
    end
    w_shifted = w_ext_val << r_s1_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= w_shifted;
        r_out_err   <= r_s1_err;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef IMM_OVF_DETECT_EN
  // Effective signedness: an illegal field is always zero-extended.
  logic r_s1_sgn;
  logic w_ovf;
  logic r_out_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_sgn <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_sgn <= w_legal & sign_en;
    end
  end

  // Bits at positions >= OUT_W-shamt are shifted out; each must match the
  // result sign (signed) or be zero (unsigned) for the value to fit.
  always_comb begin
    w_ovf = 1'b0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (i + 32'(r_s1_sh) >= OUT_W) begin
        w_ovf = w_ovf | (w_ext_val[i] ^ (r_s1_sgn & w_shifted[OUT_W-1]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_ovf <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_ovf <= w_ovf;
    end
  end

  assign out_ovf = r_out_ovf;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  localparam int unsigned IN_W  = 12;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned FW_W  = $clog2(IN_W + 1);
  localparam int unsigned SH_W  = $clog2(OUT_W);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm = '0;
  logic [FW_W-1:0]  field_w = '0;
  logic             sign_en = 1'b0;
  logic [SH_W-1:0]  shamt = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_imm;
  logic             out_err;
`ifdef IMM_OVF_DETECT_EN
  logic             out_ovf;
`endif

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    logic             err;
    logic             ovf;
  } exp_t;

  exp_t expq[$];
  exp_t cur_exp;
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  bit saw_block = 1'b0;
  bit stalled   = 1'b0;
  logic [OUT_W-1:0] held_imm;
  logic             held_err;

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .field_w(field_w), .sign_en(sign_en), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_err(out_err)
`ifdef IMM_OVF_DETECT_EN
    , .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: arithmetic on integers, then reduce modulo 2^OUT_W.
  function automatic exp_t model(input int imm, input int fw, input bit sg, input int sh);
    exp_t   r;
    int     w;
    bit     s;
    longint v;
    w = fw;
    s = sg;
    r.err = 1'b0;
    if (fw == 0 || fw > int'(IN_W)) begin
      w = IN_W;
      s = 1'b0;
      r.err = 1'b1;
    end
    v = longint'(imm) & ((longint'(1) << w) - 1);
    if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    v = v * (longint'(1) << sh);
    r.imm = v[OUT_W-1:0];
    if (s) r.ovf = (v < -(longint'(1) << (OUT_W - 1))) || (v > (longint'(1) << (OUT_W - 1)) - 1);
    else   r.ovf = (v >= (longint'(1) << OUT_W));
    return r;
  endfunction

  // Monitor: samples at negedge, i.e. the values that commit at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_imm", 32'(out_imm), 32'(held_imm));
        check("stall_err", 32'(out_err), 32'(held_err));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (expq.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          check("out_imm", 32'(out_imm), 32'(mon_e.imm));
          check("out_err", 32'(out_err), 32'(mon_e.err));
`ifdef IMM_OVF_DETECT_EN
          check("out_ovf", 32'(out_ovf), 32'(mon_e.ovf));
`endif
        end
      end
      if (in_valid && in_ready) expq.push_back(cur_exp);
      if (in_valid && !in_ready) saw_block = 1'b1;
      stalled  = out_valid && !out_ready;
      held_imm = out_imm;
      held_err = out_err;
    end
  end

  task automatic drive(input int imm, input int fw, input bit sg, input int sh, input exp_t ex);
    in_valid = 1'b1;
    in_imm   = IN_W'(imm);
    field_w  = FW_W'(fw);
    sign_en  = sg;
    shamt    = SH_W'(sh);
    cur_exp  = ex;
  endtask

  task automatic wait_accept();
    int n;
    bit acc;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_lit(input int imm, input int fw, input bit sg, input int sh,
                          input int eimm, input bit eerr, input bit eovf);
    exp_t ex;
    ex.imm = OUT_W'(eimm);
    ex.err = eerr;
    ex.ovf = eovf;
    drive(imm, fw, sg, sh, ex);
    wait_accept();
  endtask

  task automatic send_rand();
    int imm, fw, sh;
    bit sg;
    imm = int'($urandom_range(4095));
    fw  = int'($urandom_range(15));
    sg  = 1'($urandom_range(1));
    sh  = int'($urandom_range(15));
    drive(imm, fw, sg, sh, model(imm, fw, sg, sh));
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_out;
    bit acc_prev;

    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_imm", 32'(out_imm), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: accepted at edge E, out_valid visible after E+1.
    send_lit(12'h008, 4, 1'b1, 0, 16'hFFF8, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    send_lit(12'h080, 8, 1'b0, 1, 16'h0100, 1'b0, 1'b0);
    send_lit(12'h080, 8, 1'b1, 1, 16'hFF00, 1'b0, 1'b0);
    send_lit(12'hFFF, 0, 1'b1, 0, 16'h0FFF, 1'b1, 1'b0);
    send_lit(12'h123, 12, 1'b0, 0, 16'h0123, 1'b0, 1'b0);
    send_lit(12'h7FF, 12, 1'b1, 5, 16'hFFE0, 1'b0, 1'b1);
    send_lit(12'h7FF, 12, 1'b1, 4, 16'h7FF0, 1'b0, 1'b0);
    drain();

    // Back-to-back 8 items, downstream stalled for cycles 3..5.
    saw_block = 1'b0;
    base_out  = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_rand();
          wait_accept();
        end
      end
      begin
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_blocked", 32'(saw_block), 32'd1);
    check("stream_count", 32'(n_out - base_out), 32'd8);

    // Asynchronous reset while both stages hold items.
    out_ready = 1'b0;
    send_rand();
    wait_accept();
    send_rand();
    wait_accept();
    check("prerst_full_v", 32'(out_valid), 32'd1);
    check("prerst_full_r", 32'(in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_imm", 32'(out_imm), 32'd0);
    check("arst_out_err", 32'(out_err), 32'd0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(out_valid), 32'd0);

    // Random traffic with random backpressure.
    acc_prev = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc_prev) begin
        if ($urandom_range(9) < 7) send_rand();
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc_prev = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    if (in_valid && !acc_prev) wait_accept();
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
